truth_table_sweeper: RTL
========================

# truth_table_sweeper

Self-checking exhaustive stimulus engine for combinational lab circuits. On `start` it drives every N-bit input vector to a device under test, holds each vector for HOLD cycles, samples the DUT's single-bit output at the end of each hold window, and compares it against a parameterised truth table. It counts mismatches and records the first failing vector. It replaces hand-written per-vector stimulus lists in benches, and can also be synthesised for on-board self-test.

## Interface
- `N`, default 4: number of DUT inputs; 1..8.
- `TRUTH`, default 16'h6996: expected output table, width 2**N; bit `i` is the expected output for input vector `i`.
- `HOLD`, default 10: cycles each vector is applied; must be ≥1.
- `GRAY`, default 0: vector order. 0 = binary count 0..2**N-1. 1 = reflected Gray code of the index.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  launches a sweep when not busy.
- `dut_f`  in  1  DUT output under test.
- `vec`  out  N  vector currently applied to the DUT inputs (MSB = first input, e.g. A).
- `busy`  out  1  sweep in progress.
- `done`  out  1  sweep finished; sticky until the next `start` or reset.
- `pass`  out  1  equals `done` and (`err_count` == 0).
- `err_count`  out  N+1  mismatches in the current or last sweep.
- `first_fail_valid`  out  1  at least one mismatch has been recorded.
- `first_fail_vec`  out  N  applied vector of the first mismatch.

## Operation
- The FSM has three states: IDLE, APPLY, DONE.
- **Reset (asynchronous):**
  - State goes to IDLE.
  - All outputs and internal counters are set to 0.
- **IDLE or DONE, `start`=1 at a clock edge:**
  - State goes to APPLY.
  - Index `k`=0, `vec`=map(0)=0, `hold_cnt`=0.
  - `err_count`=0, `first_fail_valid`=0, `first_fail_vec`=0, `done`=0, `busy`=1.
- **APPLY, each edge:**
  - If `hold_cnt` < HOLD-1: `hold_cnt` increments.
  - Else (sample edge): compare `dut_f` with `TRUTH[vec]`.
    - On mismatch: `err_count` increments.
    - If `first_fail_valid`=0 at a mismatch: `first_fail_vec`=`vec` and `first_fail_valid`=1.
    - Then, if `k` = 2**N-1: state goes to DONE, `busy`=0, `done`=1, and `vec` holds its last value.
    - Otherwise: `k` increments, `vec`=map(`k`+1), `hold_cnt`=0.
- **Vector mapping:** map(k) = k when GRAY=0; map(k) = k ^ (k>>1) when GRAY=1.
- **Start handling:** `start` during APPLY is ignored. `start` in DONE relaunches a sweep, with the same clearing as from IDLE.
- **Width rules:**
  - `err_count` is N+1 bits, so it holds the 2**N mismatch maximum without wrap.
  - `k` never wraps past 2**N-1.
- **Registered outputs:** all outputs are registered except `pass`, which is combinational from `done` and `err_count`.

## Timing
- Edge t0 samples `start`=1. `vec`=map(0) is visible from t0 onward.
- Vector `k` is driven for exactly HOLD cycles.
- Its sample edge is t0 + (k+1)·HOLD. The DUT therefore has HOLD-1 full cycles plus one setup window to settle.
- The final compare, `done`=1 and `busy`=0 all take effect at edge t0 + 2**N·HOLD.
- Total sweep latency is 2**N·HOLD cycles. For the defaults: 160.
- If the last vector mismatches, its `err_count` update is visible in the same cycle that `done` rises.
- `rst_n` low mid-sweep:
  - All outputs clear immediately, without waiting for `clk`.
  - No partial results are retained.
  - The first `start` after reset release begins a fresh sweep.
- `start` held high continuously: a new sweep launches on the edge after `done` rises, and `done` clears there. `done` is high for exactly one cycle between back-to-back sweeps.

## Test plan
- **Golden model:** defaults (N=4, HOLD=10, GRAY=0, TRUTH=16'h6996), `dut_f` = A^B^C^D of `vec`, pulse `start`.
  - `vec` steps 0..15, each for 10 cycles.
  - `done`=1 at t0+160, `err_count`=0, `pass`=1, `first_fail_valid`=0.
- **Single fault:** `dut_f` is the golden model with the output inverted only when `vec`=6.
  - `err_count`=1, `first_fail_vec`=6, `first_fail_valid`=1, `pass`=0.
- **Fully inverted DUT:** `dut_f` inverted for every vector.
  - `err_count`=16 (5'b10000), `first_fail_vec`=0.
- **Gray order:** GRAY=1, HOLD=1.
  - `vec` sequence is 0,1,3,2,6,7,5,4,12,13,15,14,10,11,9,8, one cycle each.
  - `done` at t0+16, `pass`=1 with the golden `dut_f`.
- **Reset mid-sweep:** drop `rst_n` while `vec`=5.
  - `vec`, `busy`, `done`, `err_count` and `first_fail_*` read 0 before the next `clk` edge.
  - A later `start` completes a clean 160-cycle sweep.
- **Start while busy:** re-pulse `start` at `vec`=9.
  - It is ignored, and `done` still rises at t0+160.
  - `start` pulsed in DONE clears `done` and `err_count` and restarts from `vec`=0.

Source files
------------

// File: rtl/truth_table_sweeper_if.sv
// rtl/truth_table_sweeper_if.sv - stimulus/result bundle between a sweeper and its controller
interface truth_table_sweeper_if #(
  parameter int N = 4
) ();
  logic         start;
  logic         dut_f;
  logic [N-1:0] vec;
  logic         busy;
  logic         done;
  logic         pass;
  logic [N:0]   err_count;
  logic         first_fail_valid;
  logic [N-1:0] first_fail_vec;

  modport master (
    output start, dut_f,
    input  vec, busy, done, pass, err_count, first_fail_valid, first_fail_vec
  );

  modport slave (
    input  start, dut_f,
    output vec, busy, done, pass, err_count, first_fail_valid, first_fail_vec
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - exhaustive truth-table stimulus and compare engine
module truth_table_sweeper #(
  parameter int                 N     = 4,
  parameter logic [(1<<N)-1:0]  TRUTH = 16'h6996,
  parameter int                 HOLD  = 10,
  parameter bit                 GRAY  = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  truth_table_sweeper_if.slave    bus
);
  localparam int NV = 1 << N;
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  k_q, k_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [N-1:0]  vec_q, vec_d;
  logic [N:0]    err_q, err_d;
  logic          ffv_q, ffv_d;
  logic [N-1:0]  ffvec_q, ffvec_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  function automatic logic [N-1:0] vec_map(input logic [N-1:0] idx);
    return GRAY ? (idx ^ (idx >> 1)) : idx;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      hold_q  <= '0;
      vec_q   <= '0;
      err_q   <= '0;
      ffv_q   <= 1'b0;
      ffvec_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      hold_q  <= hold_d;
      vec_q   <= vec_d;
      err_q   <= err_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  logic sample_edge;
  logic last_vec;
  logic mismatch;

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    hold_d      = hold_q;
    vec_d       = vec_q;
    err_d       = err_q;
    ffv_d       = ffv_q;
    ffvec_d     = ffvec_q;
    busy_d      = busy_q;
    done_d      = done_q;
    sample_edge = (hold_q == HW'(HOLD - 1));
    last_vec    = (k_q == N'(NV - 1));
    mismatch    = (bus.dut_f != TRUTH[vec_q]);
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_APPLY;
          k_d     = '0;
          hold_d  = '0;
          vec_d   = vec_map('0);
          err_d   = '0;
          ffv_d   = 1'b0;
          ffvec_d = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_APPLY: begin
        if (!sample_edge) begin
          hold_d = hold_q + 1'b1;
        end else begin
          if (mismatch) begin
            err_d = err_q + 1'b1;
            if (!ffv_q) begin
              ffv_d   = 1'b1;
              ffvec_d = vec_q;
            end
          end
          // Last vector stays on the DUT inputs after the sweep ends.
          if (last_vec) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            k_d    = k_q + 1'b1;
            vec_d  = vec_map(k_q + 1'b1);
            hold_d = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.vec              = vec_q;
    bus.busy             = busy_q;
    bus.done             = done_q;
    bus.err_count        = err_q;
    bus.first_fail_valid = ffv_q;
    bus.first_fail_vec   = ffvec_q;
    bus.pass             = done_q && (err_q == '0);
  end
endmodule
